// File: rtl/axis_hdr_pkg.sv
// rtl/axis_hdr_pkg.sv - shared defaults, FSM encoding and round-robin helper for the header arbiter
package axis_hdr_pkg;

  localparam int DEF_DATA_WD = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2
  } state_t;

  // Next round-robin start position: the source after ptr, wrapping at num_src.
  function automatic int rr_next(input int ptr, input int num_src);
    return (ptr + 1 == num_src) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin priority encoder starting the search at rr_ptr
module rr_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int SRC_WD  = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_WD-1:0]  rr_ptr,
  output logic [SRC_WD-1:0]  grant,
  output logic               any_req
);

  localparam logic [SRC_WD:0] NUM_L = NUM_SRC[SRC_WD:0];

  logic [2*NUM_SRC-1:0] dbl;
  logic [NUM_SRC-1:0]   rot;
  logic [SRC_WD-1:0]    off;
  logic [SRC_WD:0]      sum;

  // Rotating the request vector puts rr_ptr at bit 0, so a fixed-priority scan does the work.
  assign dbl     = {req, req} >> rr_ptr;
  assign rot     = dbl[NUM_SRC-1:0];
  assign any_req = |rot;

  always_comb begin
    off = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (rot[k]) off = SRC_WD'(k);
    end
    sum = {1'b0, rr_ptr} + {1'b0, off};
    if (sum >= NUM_L) sum = sum - NUM_L;
    grant = sum[SRC_WD-1:0];
  end

endmodule

// File: rtl/axis_insert_header_arbiter.sv
// rtl/axis_insert_header_arbiter.sv - packet-granular round-robin arbiter feeding one header-insert datapath
module axis_insert_header_arbiter
  import axis_hdr_pkg::*;
#(
  parameter int DATA_WD      = DEF_DATA_WD,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int NUM_SRC      = 4,
  parameter int SRC_WD       = ($clog2(NUM_SRC) > 0 ? $clog2(NUM_SRC) : 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_SRC-1:0]              s_valid_insert,
  input  logic [NUM_SRC*DATA_WD-1:0]      s_data_insert,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0] s_keep_insert,
  input  logic [NUM_SRC*BYTE_CNT_WD-1:0]  s_byte_insert_cnt,
  output logic [NUM_SRC-1:0]              s_ready_insert,
  input  logic [NUM_SRC-1:0]              s_valid_in,
  input  logic [NUM_SRC*DATA_WD-1:0]      s_data_in,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0] s_keep_in,
  input  logic [NUM_SRC-1:0]              s_last_in,
  output logic [NUM_SRC-1:0]              s_ready_in,
  output logic                            valid_insert,
  output logic [DATA_WD-1:0]              data_insert,
  output logic [DATA_BYTE_WD-1:0]         keep_insert,
  output logic [BYTE_CNT_WD-1:0]          byte_insert_cnt,
  input  logic                            ready_insert,
  output logic                            valid_in,
  output logic [DATA_WD-1:0]              data_in,
  output logic [DATA_BYTE_WD-1:0]         keep_in,
  output logic                            last_in,
  input  logic                            ready_in,
  output logic [SRC_WD-1:0]               grant_id,
  output logic                            busy
);

  state_t            state;
  logic [SRC_WD-1:0] rr_ptr;
  logic [SRC_WD-1:0] arb_grant;
  logic              any_req;
  int                gi;

  rr_arbiter #(.NUM_SRC(NUM_SRC), .SRC_WD(SRC_WD)) u_rr (
    .req     (s_valid_insert),
    .rr_ptr  (rr_ptr),
    .grant   (arb_grant),
    .any_req (any_req)
  );

  assign gi   = int'(grant_id);
  assign busy = (state != ST_IDLE);

  // Ready paths depend only on registered state/grant and downstream ready, never on source valids.
  always_comb begin
    valid_insert    = 1'b0;
    data_insert     = '0;
    keep_insert     = '0;
    byte_insert_cnt = '0;
    valid_in        = 1'b0;
    data_in         = '0;
    keep_in         = '0;
    last_in         = 1'b0;
    s_ready_insert  = '0;
    s_ready_in      = '0;
    if (state == ST_HDR) begin
      valid_insert             = s_valid_insert[grant_id];
      s_ready_insert[grant_id] = ready_insert;
      if (valid_insert) begin
        data_insert     = s_data_insert[gi*DATA_WD +: DATA_WD];
        keep_insert     = s_keep_insert[gi*DATA_BYTE_WD +: DATA_BYTE_WD];
        byte_insert_cnt = s_byte_insert_cnt[gi*BYTE_CNT_WD +: BYTE_CNT_WD];
      end
    end
    if (state == ST_PAY) begin
      valid_in             = s_valid_in[grant_id];
      s_ready_in[grant_id] = ready_in;
      if (valid_in) begin
        data_in = s_data_in[gi*DATA_WD +: DATA_WD];
        keep_in = s_keep_in[gi*DATA_BYTE_WD +: DATA_BYTE_WD];
        last_in = s_last_in[grant_id];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            grant_id <= arb_grant;
            state    <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (valid_insert && ready_insert) state <= ST_PAY;
        end
        ST_PAY: begin
          if (valid_in && ready_in && last_in) begin
            rr_ptr <= SRC_WD'(rr_next(gi, NUM_SRC));
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_insert_header_arbiter.sv
// tb/tb_axis_insert_header_arbiter.sv - randomized scoreboard bench for the header arbiter
module tb_axis_insert_header_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int CW = 2;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]    s_valid_insert, s_ready_insert, s_valid_in, s_ready_in, s_last_in;
  logic [N*DW-1:0] s_data_insert, s_data_in;
  logic [N*BW-1:0] s_keep_insert, s_keep_in;
  logic [N*CW-1:0] s_byte_insert_cnt;
  logic            valid_insert, ready_insert, valid_in, ready_in, last_in, busy;
  logic [DW-1:0]   data_insert, data_in;
  logic [BW-1:0]   keep_insert, keep_in;
  logic [CW-1:0]   byte_insert_cnt;
  logic [SW-1:0]   grant_id;

  axis_insert_header_arbiter #(.DATA_WD(DW), .NUM_SRC(N)) dut (
    .clk(clk), .rst(rst),
    .s_valid_insert(s_valid_insert), .s_data_insert(s_data_insert), .s_keep_insert(s_keep_insert),
    .s_byte_insert_cnt(s_byte_insert_cnt), .s_ready_insert(s_ready_insert),
    .s_valid_in(s_valid_in), .s_data_in(s_data_in), .s_keep_in(s_keep_in),
    .s_last_in(s_last_in), .s_ready_in(s_ready_in),
    .valid_insert(valid_insert), .data_insert(data_insert), .keep_insert(keep_insert),
    .byte_insert_cnt(byte_insert_cnt), .ready_insert(ready_insert),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
    .ready_in(ready_in), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          pay;
    logic [31:0] data;
    logic [3:0]  keep;
    logic [1:0]  cnt;
    bit          last;
    int          src;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Per-source packet generators
  logic [31:0] hdr_d [N];
  logic [3:0]  hdr_k [N];
  logic [1:0]  hdr_c [N];
  logic [31:0] pay_d [N][8];
  logic [3:0]  pay_k [N][8];
  int          pay_len [N];
  int          beat [N];
  bit          have [N];
  bit          hdr_taken [N];

  logic [N-1:0] mask;
  bit  gen_en;
  int  p_hdr, p_pay, p_rdy;

  // Packet-level reference model of the arbiter
  bit  model_idle = 1'b1;
  bit  model_hdr_seen = 1'b0;
  bit  pend_free = 1'b0;
  int  model_ptr = 0;
  int  model_g = 0;
  logic [N-1:0] hs_hdr = '0, hs_pay = '0;
  bit  prev_hstall = 1'b0, prev_pstall = 1'b0;
  logic [DW-1:0] prev_hd, prev_pd;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      hs_hdr = '0;
      hs_pay = '0;
      prev_hstall = 1'b0;
      prev_pstall = 1'b0;
      chk({valid_insert, valid_in, s_ready_insert, s_ready_in, busy, grant_id, data_insert, data_in,
           keep_insert, keep_in, byte_insert_cnt, last_in} == '0, "reset_outputs",
          {valid_insert, valid_in, s_ready_insert, s_ready_in, busy, grant_id}, 0);
    end else begin
      logic [N-1:0] allowed;
      hs_hdr = s_valid_insert & s_ready_insert;
      hs_pay = s_valid_in & s_ready_in;
      chk(busy == !model_idle, "busy", busy, !model_idle);
      allowed = model_idle ? '0 : N'(1 << model_g);
      chk(((s_ready_insert | s_ready_in) & ~allowed) == '0, "ungranted_ready",
          {s_ready_insert, s_ready_in}, allowed);
      if (model_idle) chk(!valid_insert && !valid_in, "idle_valids", {valid_insert, valid_in}, 0);
      if (!model_idle && !model_hdr_seen)
        chk(s_ready_in == '0 && !valid_in, "pay_before_hdr", {s_ready_in, valid_in}, 0);
      chk((valid_insert || {data_insert, keep_insert, byte_insert_cnt} == '0) &&
          (valid_in || {data_in, keep_in, last_in} == '0), "gating",
          {valid_insert, valid_in, data_insert, data_in}, 0);
      if (prev_hstall) chk(valid_insert && data_insert == prev_hd, "hdr_hold", data_insert, prev_hd);
      if (prev_pstall) chk(valid_in && data_in == prev_pd, "pay_hold", data_in, prev_pd);
      prev_hstall = valid_insert && !ready_insert;
      prev_pstall = valid_in && !ready_in;
      prev_hd = data_insert;
      prev_pd = data_in;
      if (valid_insert && ready_insert) begin
        if (sb.size() == 0) chk(1'b0, "hdr_unexpected", data_insert, 0);
        else begin
          mon_e = sb.pop_front();
          chk(!mon_e.pay && mon_e.data == data_insert && mon_e.keep == keep_insert &&
              mon_e.cnt == byte_insert_cnt && mon_e.src == int'(grant_id), "hdr",
              {grant_id, keep_insert, byte_insert_cnt, data_insert},
              {2'(mon_e.src), mon_e.keep, mon_e.cnt, mon_e.data});
        end
        model_hdr_seen = 1'b1;
      end
      if (valid_in && ready_in) begin
        if (sb.size() == 0) chk(1'b0, "pay_unexpected", data_in, 0);
        else begin
          mon_e = sb.pop_front();
          chk(mon_e.pay && mon_e.data == data_in && mon_e.keep == keep_in && mon_e.last == last_in,
              "pay", {last_in, keep_in, data_in}, {mon_e.last, mon_e.keep, mon_e.data});
          if (mon_e.last) begin
            model_ptr = (model_g + 1) % N;
            pend_free = 1'b1;
          end
        end
      end
    end
  end

  // At each IDLE cycle the first requesting source from model_ptr onward wins the next packet.
  task automatic arb_model();
    if (!rst && model_idle && s_valid_insert != '0) begin
      int g = -1;
      exp_t e;
      for (int k = 0; k < N; k++) begin
        int c = (model_ptr + k) % N;
        if (g < 0 && s_valid_insert[c]) g = c;
      end
      e.pay = 0; e.data = hdr_d[g]; e.keep = hdr_k[g]; e.cnt = hdr_c[g]; e.last = 0; e.src = g;
      sb.push_back(e);
      for (int b = 0; b < pay_len[g]; b++) begin
        e.pay = 1; e.data = pay_d[g][b]; e.keep = pay_k[g][b]; e.cnt = 0;
        e.last = (b == pay_len[g] - 1); e.src = g;
        sb.push_back(e);
      end
      model_idle = 1'b0;
      model_hdr_seen = 1'b0;
      model_g = g;
    end
    if (pend_free) begin
      model_idle = 1'b1;
      pend_free = 1'b0;
    end
  endtask

  task automatic step_src();
    for (int i = 0; i < N; i++) begin
      if (hs_hdr[i]) begin s_valid_insert[i] = 1'b0; hdr_taken[i] = 1'b1; end
      if (hs_pay[i]) begin
        s_valid_in[i] = 1'b0;
        beat[i]++;
        if (beat[i] == pay_len[i]) have[i] = 1'b0;
      end
      if (!have[i] && gen_en && mask[i] && $urandom_range(3) == 0) begin
        have[i] = 1'b1; hdr_taken[i] = 1'b0; beat[i] = 0;
        hdr_d[i] = $urandom; hdr_k[i] = 4'($urandom); hdr_c[i] = 2'($urandom);
        pay_len[i] = $urandom_range(1, 4);
        for (int b = 0; b < 8; b++) begin pay_d[i][b] = $urandom; pay_k[i][b] = 4'($urandom); end
      end
      if (have[i] && !hdr_taken[i] && !s_valid_insert[i] && $urandom_range(99) < p_hdr) s_valid_insert[i] = 1'b1;
      if (have[i] && beat[i] < pay_len[i] && !s_valid_in[i] && $urandom_range(99) < p_pay) s_valid_in[i] = 1'b1;
      s_data_insert[i*DW +: DW]     = s_valid_insert[i] ? hdr_d[i] : $urandom;
      s_keep_insert[i*BW +: BW]     = s_valid_insert[i] ? hdr_k[i] : 4'($urandom);
      s_byte_insert_cnt[i*CW +: CW] = s_valid_insert[i] ? hdr_c[i] : 2'($urandom);
      s_data_in[i*DW +: DW]         = s_valid_in[i] ? pay_d[i][beat[i]] : $urandom;
      s_keep_in[i*BW +: BW]         = s_valid_in[i] ? pay_k[i][beat[i]] : 4'($urandom);
      s_last_in[i]                  = s_valid_in[i] ? (beat[i] == pay_len[i] - 1) : 1'($urandom);
    end
    ready_insert = ($urandom_range(99) < p_rdy);
    ready_in     = ($urandom_range(99) < p_rdy);
  endtask

  task automatic cycle();
    @(negedge clk);
    #1 arb_model();
    @(posedge clk);
    #1 step_src();
  endtask

  task automatic run(input int n, input logic [N-1:0] m, input int ph, input int pp, input int pr);
    mask = m; p_hdr = ph; p_pay = pp; p_rdy = pr;
    repeat (n) cycle();
  endtask

  task automatic clear_all();
    sb.delete();
    model_idle = 1'b1; model_hdr_seen = 1'b0; pend_free = 1'b0; model_ptr = 0; model_g = 0;
    for (int i = 0; i < N; i++) begin have[i] = 1'b0; hdr_taken[i] = 1'b0; beat[i] = 0; end
    s_valid_insert = '0; s_valid_in = '0;
  endtask

  initial begin
    bit reached;
    bit drained;
    rst = 1'b1;
    s_data_insert = '0; s_keep_insert = '0; s_byte_insert_cnt = '0;
    s_data_in = '0; s_keep_in = '0; s_last_in = '0;
    ready_insert = 1'b0; ready_in = 1'b0;
    gen_en = 1'b1;
    clear_all();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    run(150, 4'b0100, 60, 80, 80);
    run(500, 4'b1111, 100, 100, 100);
    run(800, 4'b1111, 30, 40, 40);
    run(400, 4'b1010, 70, 90, 20);

    // Reset while src0 is in the middle of its payload
    mask = 4'b0001; p_hdr = 100; p_pay = 50; p_rdy = 60;
    reached = 1'b0;
    for (int c = 0; c < 300 && !reached; c++) begin
      cycle();
      reached = !model_idle && model_hdr_seen && !pend_free && model_g == 0;
    end
    chk(reached, "reach_pay_src0", reached, 1);
    rst = 1'b1;
    clear_all();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run(400, 4'b1111, 60, 60, 60);

    gen_en = 1'b0;
    p_hdr = 100; p_pay = 100; p_rdy = 80;
    drained = 1'b0;
    for (int c = 0; c < 2000 && !drained; c++) begin
      cycle();
      drained = model_idle && !pend_free && sb.size() == 0 && !have[0] && !have[1] && !have[2] && !have[3];
    end
    chk(drained, "drain", sb.size(), 0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
